// File: rtl/conv2_ctrl_pkg.sv
// Shared types and constants for the conv-layer-2 PE column sequencer.
// Widths follow the 12-PE column: 112b ifmap, 3x24b filter rows, 240b psum.
package conv2_ctrl_pkg;

    localparam int DEF_KERNEL     = 3;
    localparam int DEF_OUT_LAT    = 5;
    localparam int DEF_MAX_COLS   = 64;
    localparam int DEF_CNT_W      = 7;
    localparam int DEF_ADDR_W     = 6;
    localparam int DEF_FIFO_DEPTH = 4;

    localparam int IF_W   = 112;
    localparam int PSUM_W = 240;
    localparam int FLT_W  = 24;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_FLT,
        S_STREAM,
        S_FLUSH,
        S_DRAIN
    } state_t;

    // Zero columns pushed after the last ifmap column to drain the array.
    function automatic int flush_beats(input int kernel, input int out_lat);
        return out_lat - kernel + 1;
    endfunction

endpackage

// File: rtl/conv2_pe_column_ctrl_psum_out_fifo.sv
// Psum output FIFO: DEPTH entries of {column index, psum}, head read
// straight from the storage registers, occupancy exported for stall logic.
module psum_out_fifo
    import conv2_ctrl_pkg::*;
#(
    parameter int DEPTH = DEF_FIFO_DEPTH,
    parameter int W     = PSUM_W + DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             wdata,
    input  logic                     pop,
    output logic [W-1:0]             rdata,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          full;
    logic          wr;
    logic          rd;

    assign full  = (count == (AW + 1)'(DEPTH));
    assign valid = (count != '0);
    assign wr    = push & ~full;
    assign rd    = pop & valid;
    assign rdata = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            assert (!(push && full));
            if (wr) begin
                mem[wr_ptr] <= wdata;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            unique case ({wr, rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/conv2_pe_column_ctrl.sv
// Sequencer for the conv-layer-2 PE column: filter load, ifmap stream,
// zero flush, psum capture into the output FIFO with backpressure stall.
module conv2_pe_column_ctrl
    import conv2_ctrl_pkg::*;
#(
    parameter int KERNEL     = DEF_KERNEL,
    parameter int OUT_LAT    = DEF_OUT_LAT,
    parameter int MAX_COLS   = DEF_MAX_COLS,
    parameter int CNT_W      = DEF_CNT_W,
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  cfg_cols,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              flt_rd_en,
    output logic [1:0]        flt_rd_addr,
    input  logic [FLT_W-1:0]  flt_rd_data,
    output logic              if_rd_en,
    output logic [ADDR_W-1:0] if_rd_addr,
    input  logic [IF_W-1:0]   if_rd_data,
    output logic              pe_en,
    output logic [IF_W-1:0]   pe_ifmap,
    output logic [FLT_W-1:0]  pe_filtr_2,
    output logic [FLT_W-1:0]  pe_filtr_1,
    output logic [FLT_W-1:0]  pe_filtr_0,
    input  logic [PSUM_W-1:0] pe_psum,
    output logic              psum_valid,
    input  logic              psum_ready,
    output logic [PSUM_W-1:0] psum_data,
    output logic [CNT_W-1:0]  psum_col
);

    localparam int FLUSH_N = flush_beats(KERNEL, OUT_LAT);
    localparam int FW      = PSUM_W + CNT_W;
    localparam int QW      = $clog2(FIFO_DEPTH) + 1;

    state_t           state;
    logic [CNT_W-1:0] cols;
    logic [CNT_W-1:0] rd_idx;
    logic [CNT_W-1:0] beat_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [1:0]       ld_cnt;
    logic             pending;
    logic             flt_vld;
    logic [1:0]       flt_vaddr;
    logic             cap_vld;
    logic [CNT_W-1:0] cap_col;
    logic [QW-1:0]    fcount;
    logic [FW-1:0]    fifo_head;

    logic             in_stream;
    logic             in_flush;
    logic             stall;
    logic             beat;
    logic             rd;
    logic             cap;
    logic             cfg_bad;
    logic [CNT_W-1:0] n_out;
    logic [CNT_W:0]   cap_hi;

    assign in_stream = (state == S_STREAM);
    assign in_flush  = (state == S_FLUSH);
    assign cfg_bad   = (cfg_cols < CNT_W'(KERNEL))
                     | (cfg_cols > CNT_W'(MAX_COLS));

    // Count the capture still in flight so the FIFO can never overfill.
    assign stall = (int'(fcount) + int'(cap_vld)) >= (FIFO_DEPTH - 1);
    assign beat  = ((in_stream & pending) | in_flush) & ~stall;
    assign rd    = in_stream & (rd_idx < cols)
                 & (~pending | beat) & ~stall;

    assign n_out  = cols - CNT_W'(KERNEL - 1);
    assign cap_hi = {1'b0, n_out} + (CNT_W + 1)'(OUT_LAT);
    assign cap    = beat & (beat_cnt >= CNT_W'(OUT_LAT))
                  & ({1'b0, beat_cnt} < cap_hi);

    assign busy       = (state != S_IDLE);
    assign pe_en      = beat;
    assign if_rd_en   = rd;
    assign if_rd_addr = rd_idx[ADDR_W-1:0];
    assign pe_ifmap   = in_stream ? if_rd_data : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_IDLE;
            cols        <= '0;
            rd_idx      <= '0;
            beat_cnt    <= '0;
            flush_cnt   <= '0;
            ld_cnt      <= '0;
            pending     <= 1'b0;
            flt_vld     <= 1'b0;
            flt_vaddr   <= '0;
            cap_vld     <= 1'b0;
            cap_col     <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
            flt_rd_en   <= 1'b0;
            flt_rd_addr <= '0;
            pe_filtr_2  <= '0;
            pe_filtr_1  <= '0;
            pe_filtr_0  <= '0;
        end else begin
            done      <= 1'b0;
            err       <= 1'b0;
            flt_vld   <= flt_rd_en;
            flt_vaddr <= flt_rd_addr;
            cap_vld   <= cap;
            if (cap) begin
                cap_col <= beat_cnt - CNT_W'(OUT_LAT);
            end
            // Filter row 0 feeds the top array input.
            if (flt_vld) begin
                unique case (1'b1)
                    (flt_vaddr == 2'd0): pe_filtr_2 <= flt_rd_data;
                    (flt_vaddr == 2'd1): pe_filtr_1 <= flt_rd_data;
                    (flt_vaddr == 2'd2): pe_filtr_0 <= flt_rd_data;
                endcase
            end
            if (rd) begin
                rd_idx  <= rd_idx + 1'b1;
                pending <= 1'b1;
            end else if (beat) begin
                pending <= 1'b0;
            end
            if (beat) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            unique case (state)
                S_IDLE: begin
                    if (start && cfg_bad) begin
                        err <= 1'b1;
                    end else if (start) begin
                        state       <= S_LOAD_FLT;
                        cols        <= cfg_cols;
                        rd_idx      <= '0;
                        beat_cnt    <= '0;
                        flush_cnt   <= '0;
                        pending     <= 1'b0;
                        ld_cnt      <= '0;
                        flt_rd_en   <= 1'b1;
                        flt_rd_addr <= 2'd0;
                    end
                end
                S_LOAD_FLT: begin
                    ld_cnt      <= ld_cnt + 2'd1;
                    flt_rd_en   <= (ld_cnt < 2'd2);
                    flt_rd_addr <= (ld_cnt < 2'd2) ? ld_cnt + 2'd1 : 2'd0;
                    if (ld_cnt == 2'd3) begin
                        state <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (beat && rd_idx == cols) begin
                        state <= S_FLUSH;
                    end
                end
                S_FLUSH: begin
                    if (beat) begin
                        flush_cnt <= flush_cnt + 1'b1;
                        if (flush_cnt == CNT_W'(FLUSH_N - 1)) begin
                            state <= S_DRAIN;
                        end
                    end
                end
                S_DRAIN: begin
                    if (fcount == '0 && !cap_vld) begin
                        done  <= 1'b1;
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    psum_out_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (FW)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (cap_vld),
        .wdata ({cap_col, pe_psum}),
        .pop   (psum_ready),
        .rdata (fifo_head),
        .valid (psum_valid),
        .count (fcount)
    );

    assign psum_col  = fifo_head[FW-1:PSUM_W];
    assign psum_data = fifo_head[PSUM_W-1:0];

endmodule

// File: tb/tb_conv2_pe_column_ctrl.sv
// Bench for conv2_pe_column_ctrl: buffer and PE-array models around the DUT,
// results compared against a direct 3x3 convolution of the buffer contents.
module tb_conv2_pe_column_ctrl;

    localparam int OUT_LAT = 5;
    localparam int KERNEL  = 3;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [6:0]   cfg_cols;
    logic         busy;
    logic         done;
    logic         err;
    logic         flt_rd_en;
    logic [1:0]   flt_rd_addr;
    logic [23:0]  flt_rd_data;
    logic         if_rd_en;
    logic [5:0]   if_rd_addr;
    logic [111:0] if_rd_data;
    logic         pe_en;
    logic [111:0] pe_ifmap;
    logic [23:0]  pe_filtr_2;
    logic [23:0]  pe_filtr_1;
    logic [23:0]  pe_filtr_0;
    logic [239:0] pe_psum;
    logic         psum_valid;
    logic         psum_ready;
    logic [239:0] psum_data;
    logic [6:0]   psum_col;

    conv2_pe_column_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .cfg_cols    (cfg_cols),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .flt_rd_en   (flt_rd_en),
        .flt_rd_addr (flt_rd_addr),
        .flt_rd_data (flt_rd_data),
        .if_rd_en    (if_rd_en),
        .if_rd_addr  (if_rd_addr),
        .if_rd_data  (if_rd_data),
        .pe_en       (pe_en),
        .pe_ifmap    (pe_ifmap),
        .pe_filtr_2  (pe_filtr_2),
        .pe_filtr_1  (pe_filtr_1),
        .pe_filtr_0  (pe_filtr_0),
        .pe_psum     (pe_psum),
        .psum_valid  (psum_valid),
        .psum_ready  (psum_ready),
        .psum_data   (psum_data),
        .psum_col    (psum_col)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [111:0] rand112();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[111:0];
    endfunction

    function automatic logic [239:0] rand240();
        logic [255:0] t;
        for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
        return t[239:0];
    endfunction

    // 3x3 conv of three 14-pixel columns -> 12 x 20b outputs.
    function automatic logic [239:0] conv(
        input logic [111:0] c0, input logic [111:0] c1,
        input logic [111:0] c2, input logic [23:0] k0,
        input logic [23:0] k1, input logic [23:0] k2);
        logic [111:0] c [3];
        logic [23:0]  k [3];
        logic [19:0]  acc;
        logic [239:0] r;
        c[0] = c0; c[1] = c1; c[2] = c2;
        k[0] = k0; k[1] = k1; k[2] = k2;
        r = '0;
        for (int row = 0; row < 12; row++) begin
            acc = '0;
            for (int kr = 0; kr < 3; kr++)
                for (int kc = 0; kc < 3; kc++)
                    acc += 20'(c[kc][(row + kr)*8 +: 8])
                         * 20'(k[kr][kc*8 +: 8]);
            r[row*20 +: 20] = acc;
        end
        return r;
    endfunction

    logic [23:0]  flt_mem [3];
    logic [111:0] if_mem [64];
    int           rdy_mode = 0;

    typedef struct packed {
        logic [6:0]   col;
        logic [239:0] data;
    } pop_t;

    // Monitor-owned bookkeeping, cleared when a start is accepted.
    logic [111:0] hist [128];
    int   flt_q [$];
    int   rd_q [$];
    pop_t pop_q [$];
    int   cyc = 0;
    int   t_cols = 0;
    int   nbeats = 0, ncaps = 0, npops = 0;
    int   ndone = 0, nerr = 0, max_out = 0;
    int   first_rd = -1, first_beat = -1, last_beat = -1;
    int   hold = 0;
    bit   busy_seen = 0, seen_valid = 0;
    bit   f_req = 0, i_req = 0, b_req = 0, rdy_next = 1;
    int   f_addr = 0, i_addr = 0, b_idx = 0;
    logic [23:0] b_f2, b_f1, b_f0;

    always @(negedge clk) begin
        int outst;
        cyc++;
        if (start && !busy) begin
            t_cols = int'(cfg_cols);
            flt_q.delete(); rd_q.delete(); pop_q.delete();
            nbeats = 0; ncaps = 0; npops = 0; ndone = 0; nerr = 0;
            max_out = 0; first_rd = -1; first_beat = -1;
            last_beat = -1; hold = 0; busy_seen = 0; seen_valid = 0;
        end
        outst = ncaps - npops;
        if (outst > max_out) max_out = outst;
        busy_seen = busy_seen | busy;
        if (done) ndone++;
        if (err) nerr++;
        f_req = flt_rd_en; f_addr = int'(flt_rd_addr);
        if (flt_rd_en) flt_q.push_back(int'(flt_rd_addr));
        i_req = if_rd_en; i_addr = int'(if_rd_addr);
        if (if_rd_en) begin
            if (first_rd < 0) first_rd = cyc;
            rd_q.push_back(int'(if_rd_addr));
        end
        b_req = pe_en; b_idx = nbeats;
        if (pe_en) begin
            hist[nbeats] = pe_ifmap;
            b_f2 = pe_filtr_2; b_f1 = pe_filtr_1; b_f0 = pe_filtr_0;
            if (first_beat < 0) first_beat = cyc;
            last_beat = cyc;
            if (nbeats >= OUT_LAT && nbeats < OUT_LAT + t_cols - KERNEL + 1)
                ncaps++;
            nbeats++;
        end
        if (psum_valid && psum_ready) begin
            pop_q.push_back({psum_col, psum_data});
            npops++;
        end
        if (rdy_mode == 0) rdy_next = 1'b1;
        else if (rdy_mode == 1) rdy_next = 1'($urandom_range(0, 1));
        else begin
            if (psum_valid) seen_valid = 1'b1;
            if (seen_valid && hold < 21) begin
                hold++;
                rdy_next = 1'b0;
            end else rdy_next = seen_valid;
        end
    end

    // Buffers respond one cycle after a read; array output follows a beat.
    always @(posedge clk) begin
        if (f_req) flt_rd_data <= flt_mem[f_addr];
        if (i_req) if_rd_data <= if_mem[i_addr];
        if (b_req) begin
            if (b_idx >= OUT_LAT)
                pe_psum <= conv(hist[b_idx-5], hist[b_idx-4], hist[b_idx-3],
                                b_f2, b_f1, b_f0);
            else
                pe_psum <= rand240();
        end
        psum_ready <= rdy_next;
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic fill_mems();
        for (int i = 0; i < 3; i++) flt_mem[i] = 24'($urandom);
        for (int i = 0; i < 64; i++) if_mem[i] = rand112();
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_ctl"}, {busy, pe_en, if_rd_en, flt_rd_en,
                            psum_valid, done, err}, '0);
        chk({tag, "_data"}, {255'(0), |{pe_ifmap, psum_data, psum_col,
             pe_filtr_2, pe_filtr_1, pe_filtr_0, if_rd_addr,
             flt_rd_addr}}, '0);
    endtask

    task automatic run_tile(input int ncols, input int mode, input bit poke);
        int n;
        int bad;
        int exp_max;
        logic [239:0] gold;
        rdy_mode = mode;
        fill_mems();
        start = 1'b1;
        cfg_cols = 7'(ncols);
        tick();
        start = 1'b0;
        n = 0;
        while (ndone == 0 && n < 3000) begin
            if (poke && n == 10) begin
                start = 1'b1;
                cfg_cols = 7'd5;
            end else start = 1'b0;
            tick();
            n++;
        end
        start = 1'b0;
        chk("tile_timeout", {255'(0), n < 3000}, 1);
        chk("flt_cnt", flt_q.size(), 3);
        for (int i = 0; i < flt_q.size() && i < 3; i++)
            chk("flt_addr", flt_q[i], i);
        chk("rd_cnt", rd_q.size(), ncols);
        bad = 0;
        foreach (rd_q[i]) if (rd_q[i] != i) bad++;
        chk("rd_seq", bad, 0);
        chk("beats", nbeats, ncols + OUT_LAT - KERNEL + 1);
        chk("pops", npops, ncols - KERNEL + 1);
        for (int i = 0; i < pop_q.size() && i < 62; i++) begin
            gold = conv(if_mem[i], if_mem[i+1], if_mem[i+2],
                        flt_mem[0], flt_mem[1], flt_mem[2]);
            chk("psum_col", pop_q[i].col, i);
            chk("psum_data", pop_q[i].data, gold);
        end
        chk("done_once", ndone, 1);
        chk("no_err", nerr, 0);
        chk("idle_after", busy, 0);
        if (mode == 0) begin
            exp_max = (ncols - KERNEL + 1 >= 2) ? 2 : 1;
            chk("beats_contig", last_beat - first_beat + 1, nbeats);
            chk("first_beat_lat", first_beat - first_rd, 1);
            chk("max_out_free", max_out, exp_max);
        end else if (mode == 2) begin
            chk("max_out_stall", max_out, 3);
        end else begin
            chk("max_out_le3", {255'(0), max_out <= 3}, 1);
        end
    endtask

    task automatic run_err(input int ncols);
        start = 1'b1;
        cfg_cols = 7'(ncols);
        tick();
        start = 1'b0;
        repeat (3) tick();
        chk("err_pulse", nerr, 1);
        chk("err_no_flt", flt_q.size(), 0);
        chk("err_no_rd", rd_q.size(), 0);
        chk("err_busy", busy_seen, 0);
        chk("err_no_done", ndone, 0);
    endtask

    initial begin
        int n;
        rst_n = 1'b0;
        start = 1'b0;
        cfg_cols = '0;
        flt_rd_data = '0;
        if_rd_data = '0;
        pe_psum = '0;
        psum_ready = 1'b1;
        repeat (3) tick();
        check_idle_outputs("reset");
        rst_n = 1'b1;
        tick();

        run_tile(14, 0, 0);
        run_err(2);
        run_err(65);
        run_tile(3, 0, 0);
        run_tile(14, 2, 0);
        run_tile(64, 1, 0);

        // Abort mid-stream with an asynchronous reset.
        rdy_mode = 0;
        fill_mems();
        start = 1'b1;
        cfg_cols = 7'd20;
        tick();
        start = 1'b0;
        n = 0;
        while (nbeats < 8 && n < 200) begin
            tick();
            n++;
        end
        chk("abort_reach", {255'(0), nbeats >= 8}, 1);
        rst_n = 1'b0;
        #1;
        check_idle_outputs("abort");
        repeat (3) tick();
        chk("abort_no_done", ndone, 0);
        rst_n = 1'b1;
        tick();
        run_tile(20, 0, 0);

        run_tile(10, 1, 1);
        run_tile(12, 0, 0);
        run_tile(16, 1, 0);

        repeat (3) tick();
        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
